// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer
//   Writer side of the double-buffered bar-height store read by the VGA pixel
//   generator. One spectrum frame of magnitude bins arrives on a valid/ready
//   stream. Each bin is scaled to an 8-bit height and written into the write
//   bank. Banks swap only on a vsync rising edge, so a displayed frame never
//   tears.
//
//   Ports:
//     clk_i       system/pixel clock
//     rst_i       synchronous, active-high reset
//     s_valid_i   input bin valid
//     s_ready_o   bin accepted this cycle when s_valid_i is also high
//     s_data_i    unsigned bin magnitude
//     s_last_i    final bin of the current spectrum
//     vsync_i     frame sync from VGA timing, active-high
//     rd_addr_i   read column from the pixel generator
//     rd_data_o   bar height for rd_addr_i, registered (1-cycle latency)
//     swapped_o   1-cycle pulse after the banks swap
//     overrun_o   sticky: producer kept pushing while a frame was pending
//
//   Optional feature: define PEAK_HOLD_EN to add a peak-hold RAM. Each stored
//   height then becomes max(h, peak - PEAK_DECAY), through a 2-stage write
//   pipeline.
//
//   state  | meaning
//   FILL   | accepting bins into the write bank
//   CLEAR  | zeroing the unused tail of a short frame
//   DRAIN  | peak pipeline flushing its last write (PEAK_HOLD_EN only)
//   PEND   | frame complete, waiting for a vsync rising edge to swap

module spectrum_frame_buffer #(
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = 9,
    parameter int IN_W       = 16,
    parameter int SHIFT      = 8,
    parameter int PEAK_DECAY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [IN_W-1:0]   s_data_i,
    input  logic              s_last_i,
    input  logic              vsync_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              swapped_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {ST_FILL, ST_CLEAR, ST_DRAIN, ST_PEND} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef PEAK_HOLD_EN
    localparam state_e FRAME_END = ST_DRAIN;
`else
    localparam state_e FRAME_END = ST_PEND;
    // The decay step only matters when peak hold is built in.
    localparam int unused_peak_decay = PEAK_DECAY;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q;
    logic              bank_sel_q;
    logic              frame_valid_q;
    logic              vsync_q;
    logic              pend_valid_q;
    logic              overrun_q;
    logic              swapped_q;
    logic [7:0]        rd_data_q;

    logic              accept;
    logic              issue;
    logic              swap;
    logic              vsync_rise;
    logic [IN_W-1:0]   shifted;
    logic [7:0]        h;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // Both banks live in one array; the top address bit selects the bank.
    logic [7:0]        bank_mem [2*DEPTH];

    assign shifted    = s_data_i >> SHIFT;
    assign h          = (shifted > IN_W'(255)) ? 8'hFF : shifted[7:0];
    assign vsync_rise = vsync_i && !vsync_q;
    assign accept     = s_valid_i && s_ready_o;
    assign issue      = accept || (state_q == ST_CLEAR);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept && (s_last_i || wptr_q == LAST_ADDR))
                    state_d = (wptr_q == LAST_ADDR) ? FRAME_END : ST_CLEAR;
            end
            ST_CLEAR: if (wptr_q == LAST_ADDR) state_d = FRAME_END;
            ST_DRAIN: state_d = ST_PEND;
            ST_PEND:  if (vsync_rise) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // Outputs decoded from state; ready is forced low during the reset cycle
    always_comb begin
        s_ready_o = 1'b0;
        swap      = 1'b0;
        case (state_q)
            ST_FILL: s_ready_o = !rst_i;
            ST_PEND: swap      = vsync_rise;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q        <= '0;
            bank_sel_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            vsync_q       <= 1'b0;
            pend_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            swapped_q     <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            vsync_q      <= vsync_i;
            swapped_q    <= swap;
            pend_valid_q <= (state_q == ST_PEND) && s_valid_i;
            if ((state_q == ST_PEND) && s_valid_i && pend_valid_q)
                overrun_q <= 1'b1;
            if (swap) begin
                bank_sel_q    <= ~bank_sel_q;
                frame_valid_q <= 1'b1;
                wptr_q        <= '0;
            end else if (issue) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            rd_data_q <= frame_valid_q ? bank_mem[{bank_sel_q, rd_addr_i}] : 8'h00;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam logic [7:0] DECAY8 = 8'(PEAK_DECAY);

    logic [7:0]        peak_mem [DEPTH];
    logic              p1_vld_q;
    logic              peak_valid_q;
    logic [ADDR_W-1:0] p1_addr_q;
    logic [7:0]        p1_h_q;
    logic [7:0]        p1_peak_q;
    logic [7:0]        decayed;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p1_vld_q     <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            p1_vld_q <= issue;
            // Peak RAM is not cleared by reset; reuse it only after one
            // complete frame has rewritten every address.
            if (swap) peak_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            p1_addr_q <= wptr_q;
            p1_h_q    <= accept ? h : 8'h00;
            p1_peak_q <= peak_mem[wptr_q];
        end
    end

    always_comb begin
        decayed = (p1_peak_q >= DECAY8) ? (p1_peak_q - DECAY8) : 8'h00;
        wr_data = (peak_valid_q && (decayed > p1_h_q)) ? decayed : p1_h_q;
        wr_en   = p1_vld_q;
        wr_addr = p1_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) peak_mem[wr_addr] <= wr_data;
    end
`else
    always_comb begin
        wr_en   = issue;
        wr_addr = wptr_q;
        wr_data = accept ? h : 8'h00;
    end
`endif

    // The write bank is always the one not being displayed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) bank_mem[{~bank_sel_q, wr_addr}] <= wr_data;
    end

    assign rd_data_o = rd_data_q;
    assign swapped_o = swapped_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
module tb_spectrum_frame_buffer;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] s_data = '0;
    logic [8:0]  rd_addr = '0;
    logic        s_ready;
    logic        swapped;
    logic        overrun;
    logic [7:0]  rd_data;

    int errors = 0;
    int checks = 0;
    int nr;
    int zero_bad;
    bit watch_zero = 1'b0;

    logic [15:0] fr [DEPTH];

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] exp;
    } rd_t;

    rd_t         sb [$];
    int          pa [$];
    logic [7:0]  pe [$];

    always #5 clk = ~clk;

    spectrum_frame_buffer dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .vsync_i   (vsync),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .swapped_o (swapped),
        .overrun_o (overrun)
    );

    function automatic logic [7:0] scale(logic [15:0] d);
        logic [15:0] s;
        s = d >> 8;
        return (s > 16'd255) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] expv(int a, int nbins);
        return (a < nbins) ? scale(fr[a]) : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(int n, bit use_last, bit vs_on_last);
        nr = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = fr[i];
            s_last  = use_last && (i == n - 1);
            if (vs_on_last && (i == n - 1)) vsync = 1'b1;
            if (s_ready !== 1'b1) nr++;
            tick();
            if (watch_zero && rd_data !== 8'h00) zero_bad++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic swap_window(string tag);
        int cnt;
        cnt = 0;
        vsync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (watch_zero && rd_data !== 8'h00) zero_bad++;
            if (swapped === 1'b1) begin
                cnt++;
                watch_zero = 1'b0;
            end
        end
        vsync = 1'b0;
        chk(tag, cnt, 1);
    endtask

    task automatic q_rd(int a, logic [7:0] e);
        pa.push_back(a);
        pe.push_back(e);
    endtask

    // Back-to-back reads: the next address is driven before the previous
    // result is checked, so a zero-latency read path returns the wrong value.
    task automatic read_seq();
        rd_t e;
        int  n;
        n = pa.size();
        rd_addr = 9'(pa[0]);
        e.addr = 9'(pa[0]);
        e.exp  = pe[0];
        sb.push_back(e);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 < n) begin
                rd_addr = 9'(pa[k+1]);
                e.addr = 9'(pa[k+1]);
                e.exp  = pe[k+1];
                sb.push_back(e);
            end
            #1;
            e = sb.pop_front();
            chk($sformatf("rd_data@%0d", e.addr), {24'd0, rd_data}, {24'd0, e.exp});
        end
        pa.delete();
        pe.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        rd_addr = 9'd37;
        tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_swapped", swapped, 0);
        chk("rst_overrun", overrun, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ready_after_rst", s_ready, 1);

`ifdef PEAK_HOLD_EN
        for (int i = 0; i < DEPTH; i++) fr[i] = '0;
        fr[5] = 16'(200 << 8);
        send_frame(6, 1'b1, 1'b0);
        chk("peakA_fill_ready", nr, 0);
        repeat (520) tick();
        swap_window("peakA_swap");
        q_rd(5, 8'd200);
        read_seq();

        fr[5] = '0;
        send_frame(6, 1'b1, 1'b0);
        chk("peakB_fill_ready", nr, 0);
        repeat (520) tick();
        swap_window("peakB_swap");
        q_rd(5, 8'd198);
        q_rd(4, 8'd0);
        read_seq();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_frame(6, 1'b1, 1'b0);
        chk("peakC_fill_ready", nr, 0);
        repeat (520) tick();
        swap_window("peakC_swap");
        q_rd(5, 8'd0);
        read_seq();
`else
        // Full frame, heights follow the bin index
        for (int i = 0; i < DEPTH; i++) fr[i] = 16'(i << 8);
        watch_zero = 1'b1;
        zero_bad   = 0;
        send_frame(DEPTH, 1'b1, 1'b0);
        chk("full_fill_ready", nr, 0);
        tick();
        chk("pend_ready_low", s_ready, 0);
        swap_window("full_swap");
        chk("rd_zero_before_swap", zero_bad, 0);
        q_rd(100, 8'd100);
        q_rd(37, expv(37, DEPTH));
        q_rd(300, expv(300, DEPTH));
        q_rd(511, expv(511, DEPTH));
        q_rd(0, 8'd0);
        read_seq();

        // Saturation and truncation
        fr[0] = 16'hFFFF;
        fr[1] = 16'h00FF;
        fr[2] = 16'h1234;
        send_frame(3, 1'b1, 1'b0);
        chk("sat_fill_ready", nr, 0);
        repeat (520) tick();
        swap_window("sat_swap");
        q_rd(0, 8'd255);
        q_rd(1, 8'd0);
        q_rd(2, 8'h12);
        q_rd(3, 8'd0);
        q_rd(511, 8'd0);
        read_seq();

        // Short frame: tail is cleared; vsync during clear must not swap
        for (int i = 0; i < 10; i++) fr[i] = 16'h4000;
        send_frame(10, 1'b1, 1'b0);
        chk("short_fill_ready", nr, 0);
        nr  = 0;
        cnt = 0;
        for (int k = 0; k < 502; k++) begin
            if (k == 100) vsync = 1'b1;
            if (k == 101) vsync = 1'b0;
            if (s_ready !== 1'b0) nr++;
            tick();
            if (swapped === 1'b1) cnt++;
        end
        chk("short_ready_low_502", nr, 0);
        chk("short_no_swap_in_clear", cnt, 0);
        swap_window("short_swap");
        q_rd(9, 8'd64);
        q_rd(10, 8'd0);
        q_rd(11, 8'd0);
        q_rd(200, 8'd0);
        q_rd(511, 8'd0);
        q_rd(0, 8'd64);
        read_seq();

        // Full frame completing together with a vsync edge, then overrun
        for (int i = 0; i < DEPTH; i++) fr[i] = 16'((i * 37) << 4);
        send_frame(DEPTH, 1'b1, 1'b1);
        chk("coin_fill_ready", nr, 0);
        cnt = 0;
        s_valid = 1'b1;
        s_data  = 16'hABCD;
        tick();
        if (swapped === 1'b1) cnt++;
        chk("overrun_one_cycle", overrun, 0);
        tick();
        if (swapped === 1'b1) cnt++;
        chk("overrun_set", overrun, 1);
        tick();
        if (swapped === 1'b1) cnt++;
        s_valid = 1'b0;
        vsync   = 1'b0;
        tick();
        if (swapped === 1'b1) cnt++;
        chk("coin_no_swap", cnt, 0);
        swap_window("coin_late_swap");
        chk("overrun_sticky", overrun, 1);
        q_rd(0, expv(0, DEPTH));
        q_rd(1, expv(1, DEPTH));
        q_rd(255, expv(255, DEPTH));
        q_rd(256, expv(256, DEPTH));
        q_rd(511, expv(511, DEPTH));
        read_seq();

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) fr[i] = 16'h0100;
        send_frame(5, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", s_ready, 0);
        tick();
        rst = 1'b0;
        chk("rst_clears_overrun", overrun, 0);
        q_rd(0, 8'd0);
        read_seq();
        fr[0] = 16'h0500;
        fr[1] = 16'h0600;
        send_frame(2, 1'b1, 1'b0);
        chk("post_rst_fill_ready", nr, 0);
        repeat (520) tick();
        swap_window("post_rst_swap");
        q_rd(0, 8'd5);
        q_rd(1, 8'd6);
        q_rd(2, 8'd0);
        q_rd(4, 8'd0);
        read_seq();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
